// File: rtl/moist_sens_fe.sv
// Soil-moisture sensor front end: triggers an external ADC, averages 2**AVG_LOG2
// conversions into an 8-bit level, and forces a safe "wet" level on a hung ADC.
module moist_sens_fe #(
  parameter int unsigned ADC_W    = 10,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SMP_GAP  = 16,
  parameter int unsigned TMO      = 64,
  parameter int unsigned FLT_MAX  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_done,
  output logic             adc_start,
  output logic [7:0]       wtr_lvl,
  output logic             lvl_vld,
  output logic             sens_flt
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned SMP_W = AVG_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(TMO);
  localparam int unsigned GAP_W = $clog2(SMP_GAP + 1);
  localparam int unsigned FLT_W = $clog2(FLT_MAX + 1);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((2 ** AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SMP_GAP - 1);
  localparam logic [FLT_W-1:0] FLT_SAT  = FLT_W'(FLT_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    UPDATE = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_acc_sum;
  logic [SMP_W-1:0] r_smp_cnt;
  logic [SMP_W-1:0] w_smp_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [FLT_W-1:0] r_flt_cnt;
  logic [FLT_W-1:0] w_flt_nxt;
  logic [FLT_W-1:0] w_flt_inc;
  logic             r_adc_start;
  logic             w_adc_start_nxt;
  logic [7:0]       r_wtr_lvl;
  logic [7:0]       w_wtr_lvl_nxt;
  logic             r_lvl_vld;
  logic             w_lvl_vld_nxt;
  logic             r_sens_flt;
  logic             w_sens_flt_nxt;

  assign w_acc_sum = r_acc + ACC_W'(adc_data);
  assign w_flt_inc = (r_flt_cnt == FLT_SAT) ? FLT_SAT : r_flt_cnt + FLT_W'(1);

  // Next state plus next values of every register. Registered outputs are computed
  // from the transition so they are valid during the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_smp_nxt       = r_smp_cnt;
    w_tmo_nxt       = r_tmo_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_flt_nxt       = r_flt_cnt;
    w_wtr_lvl_nxt   = r_wtr_lvl;
    w_sens_flt_nxt  = r_sens_flt;
    w_adc_start_nxt = 1'b0;
    w_lvl_vld_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = START;
      end
      START: begin
        w_tmo_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (adc_done) begin
          w_acc_nxt = w_acc_sum;
          w_smp_nxt = r_smp_cnt + SMP_W'(1);
          if (r_smp_cnt == SMP_LAST) begin
            // Publish on this edge so the level appears during UPDATE.
            w_wtr_lvl_nxt  = w_acc_sum[ACC_W-1 -: 8];
            w_sens_flt_nxt = 1'b0;
            w_state_nxt    = UPDATE;
          end else begin
            w_state_nxt = GAP;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_acc_nxt   = '0;
          w_smp_nxt   = '0;
          w_tmo_nxt   = '0;
          w_flt_nxt   = w_flt_inc;
          w_state_nxt = GAP;
          if (w_flt_inc == FLT_SAT) begin
            w_sens_flt_nxt = 1'b1;
            w_wtr_lvl_nxt  = 8'hFF;
          end
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      UPDATE: begin
        w_acc_nxt   = '0;
        w_smp_nxt   = '0;
        w_flt_nxt   = '0;
        w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_nxt   = '0;
          w_state_nxt = START;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_adc_start_nxt = (w_state_nxt == START);
    w_lvl_vld_nxt   = (w_state_nxt == UPDATE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_smp_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_flt_cnt   <= '0;
      r_adc_start <= 1'b0;
      r_wtr_lvl   <= 8'hFF;
      r_lvl_vld   <= 1'b0;
      r_sens_flt  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_smp_cnt   <= w_smp_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_flt_cnt   <= w_flt_nxt;
      r_adc_start <= w_adc_start_nxt;
      r_wtr_lvl   <= w_wtr_lvl_nxt;
      r_lvl_vld   <= w_lvl_vld_nxt;
      r_sens_flt  <= w_sens_flt_nxt;
    end
  end

  assign adc_start = r_adc_start;
  assign wtr_lvl   = r_wtr_lvl;
  assign lvl_vld   = r_lvl_vld;
  assign sens_flt  = r_sens_flt;

endmodule

// File: tb/tb_moist_sens_fe.sv
// Scoreboard bench for moist_sens_fe: an ADC responder issues conversions, a sample-list
// model predicts averages and fault events, and a monitor checks what the DUT publishes.
module tb_moist_sens_fe;

  localparam int unsigned ADC_W    = 10;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned SMP_GAP  = 16;
  localparam int unsigned TMO      = 64;
  localparam int unsigned FLT_MAX  = 3;
  localparam int unsigned NSMP     = 1 << AVG_LOG2;
  localparam int unsigned SHIFT    = ADC_W + AVG_LOG2 - 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [ADC_W-1:0] adc_data;
  logic             adc_done;
  logic             adc_start;
  logic [7:0]       wtr_lvl;
  logic             lvl_vld;
  logic             sens_flt;

  moist_sens_fe #(
    .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .SMP_GAP(SMP_GAP), .TMO(TMO), .FLT_MAX(FLT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_done(adc_done),
    .adc_start(adc_start), .wtr_lvl(wtr_lvl), .lvl_vld(lvl_vld), .sens_flt(sens_flt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_flt;
    logic [7:0] lvl;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned m_samples[$];
  int          m_flt      = 0;
  bit          m_faulted  = 1'b0;
  int          next_start = -1;
  int          n_chk      = 0;
  int          n_fail     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // Reference model: collect samples; a full set yields their truncated mean.
  function automatic bit model_accept(input int unsigned data, input int c);
    int unsigned sum;
    exp_t e;
    m_samples.push_back(data);
    if (m_samples.size() < NSMP) return 1'b0;
    sum = 0;
    foreach (m_samples[i]) sum += m_samples[i];
    e.is_flt = 1'b0;
    e.lvl    = 8'(sum >> SHIFT);
    e.cyc    = c + 1;
    sb_q.push_back(e);
    m_samples.delete();
    m_flt     = 0;
    m_faulted = 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_timeout(input int s);
    exp_t e;
    m_samples.delete();
    if (m_flt < int'(FLT_MAX)) m_flt++;
    if (m_flt == int'(FLT_MAX) && !m_faulted) begin
      m_faulted = 1'b1;
      e.is_flt  = 1'b1;
      e.lvl     = 8'hFF;
      e.cyc     = s + int'(TMO) + 1;
      sb_q.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    m_samples.delete();
    m_flt     = 0;
    m_faulted = 1'b0;
  endfunction

  task automatic wait_start(output int s);
    s = -1;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (adc_start === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL start_wait: no adc_start within 200 cycles (cycle %0d)", cyc);
      finish_run();
    end else if (next_start >= 0) begin
      check("start_cadence", 32'(s), 32'(next_start));
    end
  endtask

  // One conversion: answer on WAIT cycle k (1..TMO) or never answer.
  task automatic do_conv(input bit never, input logic [ADC_W-1:0] data, input int k);
    int s;
    bit upd;
    wait_start(s);
    if (never) begin
      model_timeout(s);
      next_start = s + int'(TMO) + int'(SMP_GAP) + 1;
      repeat (TMO + 2) @(posedge clk);
    end else begin
      repeat (k) @(posedge clk);
      #1;
      adc_done = 1'b1;
      adc_data = data;
      upd = model_accept(int'(data), cyc);
      next_start = cyc + int'(SMP_GAP) + 1 + (upd ? 1 : 0);
      @(posedge clk);
      #1;
      adc_done = 1'b0;
      adc_data = ADC_W'($urandom);
      // Spurious done during GAP must be ignored.
      repeat (3) @(posedge clk);
      #1;
      adc_done = 1'b1;
      adc_data = ADC_W'($urandom);
      @(posedge clk);
      #1;
      adc_done = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_adc_start"}, 32'(adc_start), 32'd0);
    check({tag, "_wtr_lvl"},   32'(wtr_lvl),   32'd255);
    check({tag, "_lvl_vld"},   32'(lvl_vld),   32'd0);
    check({tag, "_sens_flt"},  32'(sens_flt),  32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_start = cyc + 1;
  endtask

  // Monitor: pops the scoreboard on every published level or fault rise.
  initial begin
    bit         prev_flt;
    bit         prev_start;
    logic [7:0] hold_lvl;
    bit         hold_flt;
    exp_t       e;
    prev_flt   = 1'b0;
    prev_start = 1'b0;
    hold_lvl   = 8'hFF;
    hold_flt   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_flt   = 1'b0;
        prev_start = 1'b0;
        hold_lvl   = 8'hFF;
        hold_flt   = 1'b0;
      end else begin
        if (adc_start === 1'b1) check("start_width", 32'(prev_start), 32'd0);
        if (lvl_vld === 1'b1 || (sens_flt === 1'b1 && !prev_flt)) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: lvl_vld=%0d sens_flt=%0d wtr_lvl=%0d, none expected (cycle %0d)",
                     lvl_vld, sens_flt, wtr_lvl, cyc);
          end else begin
            e = sb_q.pop_front();
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            check("event_lvl_vld", 32'(lvl_vld), 32'(!e.is_flt));
            check("event_sens_flt", 32'(sens_flt), 32'(e.is_flt));
            check("event_wtr_lvl", 32'(wtr_lvl), 32'(e.lvl));
            hold_lvl = e.lvl;
            hold_flt = e.is_flt;
          end
        end else begin
          check("hold_wtr_lvl", 32'(wtr_lvl), 32'(hold_lvl));
          check("hold_sens_flt", 32'(sens_flt), 32'(hold_flt));
        end
        prev_flt   = (sens_flt === 1'b1);
        prev_start = (adc_start === 1'b1);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    adc_done = 1'b0;
    adc_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    release_reset();
    @(negedge clk);
    check_reset_vals("post_release");

    repeat (4) do_conv(1'b0, 10'd200, 3);
    do_conv(1'b0, 10'd100, 3);
    do_conv(1'b0, 10'd200, 3);
    do_conv(1'b0, 10'd300, 3);
    do_conv(1'b0, 10'd400, 3);
    repeat (4) do_conv(1'b0, 10'd1023, 3);
    repeat (4) do_conv(1'b0, 10'd0, 3);

    // Hung ADC: fault on the third timeout, saturate, then recover.
    repeat (4) do_conv(1'b1, '0, 0);
    repeat (4) do_conv(1'b0, 10'd200, 3);

    // Done on the last WAIT cycle wins over timeout.
    repeat (2) do_conv(1'b1, '0, 0);
    do_conv(1'b0, 10'd500, TMO);
    repeat (3) do_conv(1'b0, 10'd600, 5);
    repeat (2) do_conv(1'b1, '0, 0);
    repeat (4) do_conv(1'b0, 10'd800, TMO);

    // Reset in WAIT discards the partial accumulation.
    repeat (2) do_conv(1'b0, 10'd1023, 3);
    begin
      int s;
      wait_start(s);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      check_reset_vals("mid_wait_reset");
      release_reset();
    end
    repeat (4) do_conv(1'b0, 10'd40, 3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) do_conv(1'b1, '0, 0);
      else do_conv(1'b0, ADC_W'($urandom), int'($urandom_range(1, TMO)));
    end

    repeat (30) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    finish_run();
  end

endmodule
